// File: rtl/countdown_timer.sv
// MM:SS countdown timer: user-set preset, 1 Hz countdown to 00:00, alarm on expiry.
// Optional COUNTDOWN_BLINK_EN makes the alarm blink at 1 Hz while expired.
module countdown_timer #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       modo_timer,
  input  logic       modo_ajuste_timer,
  input  logic       flag_ajuste_timer,
  input  logic       btn_start,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned MIN_W   = 7;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned PRESC_W = $clog2(CLK_HZ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [MIN_W-1:0]   preset_min, preset_min_nxt;
  logic [SEC_W-1:0]   preset_sec, preset_sec_nxt;
  logic [MIN_W-1:0]   count_min, count_min_nxt;
  logic [SEC_W-1:0]   count_sec, count_sec_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [MIN_W-1:0]   minutes_nxt;
  logic [SEC_W-1:0]   seconds_nxt;
  logic               running_nxt;
  logic               alarm_nxt;
  logic               tick;
  logic               start_ok;
  logic               last_sec;

  // Next-state, preset edit, countdown and display mux
  always_comb begin
    state_nxt      = state;
    preset_min_nxt = preset_min;
    preset_sec_nxt = preset_sec;
    count_min_nxt  = count_min;
    count_sec_nxt  = count_sec;
    presc_nxt      = presc;
    tick           = 1'b0;
    start_ok       = btn_start && modo_timer;
    last_sec       = (count_min == '0) && (count_sec <= SEC_W'(1));

    if (modo_ajuste_timer) begin
      if (btn_inc_sec)
        preset_sec_nxt = (preset_sec == SEC_W'(59)) ? '0 : preset_sec + SEC_W'(1);
      if (btn_inc_min)
        preset_min_nxt = (preset_min == MIN_W'(MAX_MIN)) ? '0 : preset_min + MIN_W'(1);
    end

    if (flag_ajuste_timer) begin
      count_min_nxt = preset_min;
      count_sec_nxt = preset_sec;
      presc_nxt     = '0;
      state_nxt     = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok && ((count_min != '0) || (count_sec != '0)))
            state_nxt = ST_RUNNING;
        end
        ST_RUNNING: begin
          tick      = (presc == PRESC_W'(CLK_HZ - 1));
          presc_nxt = tick ? '0 : presc + PRESC_W'(1);
          if (tick) begin
            if (count_sec != '0) begin
              count_sec_nxt = count_sec - SEC_W'(1);
            end else if (count_min != '0) begin
              count_sec_nxt = SEC_W'(59);
              count_min_nxt = count_min - MIN_W'(1);
            end
          end
          // Reaching 00:00 wins over a simultaneous pause request
          if (tick && last_sec) begin
            state_nxt = ST_EXPIRED;
            presc_nxt = '0;
          end else if (start_ok) begin
            state_nxt = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (start_ok)
            state_nxt = ST_RUNNING;
        end
        ST_EXPIRED: begin
          if (start_ok) begin
            state_nxt     = ST_IDLE;
            count_min_nxt = preset_min;
            count_sec_nxt = preset_sec;
            presc_nxt     = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    minutes_nxt = modo_ajuste_timer ? preset_min_nxt : count_min_nxt;
    seconds_nxt = modo_ajuste_timer ? preset_sec_nxt : count_sec_nxt;
    running_nxt = (state_nxt == ST_RUNNING);
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int unsigned HALF_CNT = CLK_HZ / 2;
  localparam int unsigned HALF_W   = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;

  logic [HALF_W-1:0] half_cnt, half_cnt_nxt;

  // Half-second blink counter, alive only while expired
  always_comb begin
    half_cnt_nxt = '0;
    alarm_nxt    = 1'b0;
    if (state_nxt == ST_EXPIRED) begin
      if (state != ST_EXPIRED) begin
        alarm_nxt = 1'b1;
      end else if (half_cnt == HALF_W'(HALF_CNT - 1)) begin
        alarm_nxt = ~alarm;
      end else begin
        alarm_nxt    = alarm;
        half_cnt_nxt = half_cnt + HALF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) half_cnt <= '0;
    else        half_cnt <= half_cnt_nxt;
  end
`else
  assign alarm_nxt = (state_nxt == ST_EXPIRED);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      preset_min <= '0;
      preset_sec <= '0;
      count_min  <= '0;
      count_sec  <= '0;
      presc      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nxt;
      preset_min <= preset_min_nxt;
      preset_sec <= preset_sec_nxt;
      count_min  <= count_min_nxt;
      count_sec  <= count_sec_nxt;
      presc      <= presc_nxt;
      minutes    <= minutes_nxt;
      seconds    <= seconds_nxt;
      running    <= running_nxt;
      alarm      <= alarm_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a total-seconds reference model predicts
// each cycle's outputs; a separate monitor pops and compares them.
module tb_countdown_timer;

  localparam int CLK_HZ  = 4;
  localparam int MAX_MIN = 99;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
  typedef struct packed {
    logic [6:0] mm;
    logic [5:0] ss;
    logic       run;
    logic       alm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       modo_timer = 1'b0;
  logic       modo_ajuste_timer = 1'b0;
  logic       flag_ajuste_timer = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_inc_min = 1'b0;
  logic       btn_inc_sec = 1'b0;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       alarm;

  countdown_timer #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN)) dut (
    .clk               (clk),
    .reset             (reset),
    .modo_timer        (modo_timer),
    .modo_ajuste_timer (modo_ajuste_timer),
    .flag_ajuste_timer (flag_ajuste_timer),
    .btn_start         (btn_start),
    .btn_inc_min       (btn_inc_min),
    .btn_inc_sec       (btn_inc_sec),
    .minutes           (minutes),
    .seconds           (seconds),
    .running           (running),
    .alarm             (alarm)
  );

  always #5 clk = ~clk;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: count kept as total seconds, phase = cycles into current second
  mode_t m_st = M_IDLE;
  int    m_cnt = 0;
  int    m_pm = 0;
  int    m_ps = 0;
  int    m_phase = 0;
  int    m_exp_cyc = 0;

  task automatic model_step(input bit r, input bit tm, input bit ta, input bit fl,
                            input bit st, input bit im, input bit is, output exp_t e);
    int old_preset;
    bit tick;
    if (!r) begin
      m_st = M_IDLE; m_cnt = 0; m_pm = 0; m_ps = 0; m_phase = 0; m_exp_cyc = 0;
      e = '0;
      return;
    end
    old_preset = m_pm * 60 + m_ps;
    if (ta) begin
      if (is) m_ps = (m_ps + 1) % 60;
      if (im) m_pm = (m_pm + 1) % (MAX_MIN + 1);
    end
    if (fl) begin
      m_cnt = old_preset; m_phase = 0; m_st = M_IDLE;
    end else if (m_st == M_RUN) begin
      tick = (m_phase == CLK_HZ - 1);
      m_phase = (m_phase + 1) % CLK_HZ;
      if (tick && m_cnt > 0) m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_st = M_EXP; m_phase = 0; m_exp_cyc = 0;
      end else if (st && tm) begin
        m_st = M_PAUSE;
      end
    end else if (st && tm) begin
      case (m_st)
        M_IDLE:  if (m_cnt != 0) m_st = M_RUN;
        M_PAUSE: m_st = M_RUN;
        M_EXP:   begin m_st = M_IDLE; m_cnt = old_preset; m_phase = 0; end
        default: ;
      endcase
    end else if (m_st == M_EXP) begin
      m_exp_cyc = m_exp_cyc + 1;
    end
    e.mm  = 7'(ta ? m_pm : m_cnt / 60);
    e.ss  = 6'(ta ? m_ps : m_cnt % 60);
    e.run = (m_st == M_RUN);
`ifdef COUNTDOWN_BLINK_EN
    e.alm = (m_st == M_EXP) && (((m_exp_cyc / (CLK_HZ / 2)) % 2) == 0);
`else
    e.alm = (m_st == M_EXP);
`endif
  endtask

  // One cycle of stimulus: drive on the falling edge, push the prediction for the next rise
  task automatic drive(input bit r, input bit tm, input bit ta, input bit fl,
                       input bit st, input bit im, input bit is);
    exp_t e;
    @(negedge clk);
    reset = r; modo_timer = tm; modo_ajuste_timer = ta; flag_ajuste_timer = fl;
    btn_start = st; btn_inc_min = im; btn_inc_sec = is;
    model_step(r, tm, ta, fl, st, im, is, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit tm, input bit ta);
    for (int i = 0; i < n; i++) drive(1, tm, ta, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle, checked 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (minutes !== e.mm) begin
          n_fail++;
          $display("FAIL minutes @%0t: got %0d expected %0d", $time, minutes, e.mm);
        end
        n_tests++;
        if (seconds !== e.ss) begin
          n_fail++;
          $display("FAIL seconds @%0t: got %0d expected %0d", $time, seconds, e.ss);
        end
        n_tests++;
        if (running !== e.run) begin
          n_fail++;
          $display("FAIL running @%0t: got %0b expected %0b", $time, running, e.run);
        end
        n_tests++;
        if (alarm !== e.alm) begin
          n_fail++;
          $display("FAIL alarm @%0t: got %0b expected %0b", $time, alarm, e.alm);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset, then start with zero count is ignored
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(3, 1, 0);
    // Adjust to 02:01 with seconds wrapping once
    repeat (2)  drive(1, 0, 1, 0, 0, 1, 0);
    repeat (61) drive(1, 0, 1, 0, 0, 0, 1);
    idle(2, 0, 1);
    drive(1, 0, 1, 1, 0, 0, 0);
    idle(3, 1, 0);
    // Preset 00:02, run to expiry, acknowledge
    repeat (98) drive(1, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(14, 1, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(3, 1, 0);
    // Preset 01:00, pause/resume keeping the prescaler phase
    drive(1, 0, 1, 0, 0, 1, 0);
    repeat (58) drive(1, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(5, 1, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(20, 1, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(10, 1, 0);
    // Load and start in the same cycle while running
    drive(1, 1, 0, 1, 1, 0, 0);
    idle(3, 1, 0);
    // Minutes wrap at MAX_MIN, both increments together
    repeat (99) drive(1, 0, 1, 0, 0, 1, 0);
    idle(1, 0, 1);
    drive(1, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 1, 1);
    // Reset mid-count
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 0);
    idle(6, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(3, 1, 0);
    // Randomized segments with short presets so expiry happens often
    for (int seg = 0; seg < 24; seg++) begin
      if ($urandom_range(0, 1) == 0) drive(0, 0, 0, 0, 0, 0, 0);
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) drive(1, 0, 1, 0, 0, 1, 0);
      drive(1, 0, 1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 160; i++)
        drive(1, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
